// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, event type and frame check helper for the PS/2
// keyboard receive path.
//   PS2_EXT_PREFIX / PS2_BRK_PREFIX : prefix scan codes merged into events
//   PS2_FRAME_BITS                  : start + 8 data + parity + stop
//   ps2_evt_t                       : {ext, brk, code[7:0]} key event
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Start bit low, stop bit high, odd parity over data+parity bits.
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return ~f[0] & f[PS2_FRAME_BITS-1] & (^f[PS2_FRAME_BITS-2:1]);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes the PS/2 lines, detects falling clock edges,
// deframes 11-bit frames LSB-first and validates start/parity/stop.
// Optional watchdog (macro PS2_TIMEOUT_EN) aborts a stalled partial frame.
// Ports:
//   i_clk, i_rst      system clock, synchronous active-high reset
//   i_ps2_clk/data    asynchronous PS/2 lines
//   o_byte_valid      one-cycle pulse, o_byte holds the accepted data byte
//   o_byte            last accepted data byte
//   o_frame_err       one-cycle pulse on a dropped frame (or timeout)
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("ps2_frame_rx: TIMEOUT_CYC must be >= 2");
  end

  logic                      r_clk_s1, r_clk_s2, r_clk_hist;
  logic                      r_dat_s1, r_dat_s2;
  logic [PS2_FRAME_BITS-2:0] r_shift;
  logic [3:0]                r_cnt;
  logic                      r_byte_valid, r_frame_err;
  logic [7:0]                r_byte;

  logic                      w_fall;
  logic [PS2_FRAME_BITS-1:0] w_frame;
  logic                      w_wd_expire;

  assign w_fall  = r_clk_hist & ~r_clk_s2;
  // Incoming bit lands at the MSB; after 11 falls the start bit sits at bit 0.
  assign w_frame = {r_dat_s2, r_shift};

`ifdef PS2_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] r_wd;

  assign w_wd_expire = (r_cnt != 4'd0) && !w_fall && (r_wd == WD_W'(TIMEOUT_CYC - 1));

  // Runs only while a frame is partially received; any fall restarts it.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_fall || r_cnt == 4'd0 || w_wd_expire) r_wd <= '0;
    else                                                  r_wd <= r_wd + 1'b1;
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_clk_hist   <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_shift      <= '0;
      r_cnt        <= 4'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte       <= 8'h00;
    end else begin
      r_clk_s1     <= i_ps2_clk;
      r_clk_s2     <= r_clk_s1;
      r_clk_hist   <= r_clk_s2;
      r_dat_s1     <= i_ps2_data;
      r_dat_s2     <= r_dat_s1;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall) begin
        r_shift <= w_frame[PS2_FRAME_BITS-1:1];
        if (r_cnt == LAST_BIT) begin
          r_cnt <= 4'd0;
          if (frame_ok(w_frame)) begin
            r_byte_valid <= 1'b1;
            r_byte       <= w_frame[8:1];
          end else begin
            r_frame_err  <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else if (w_wd_expire) begin
        r_cnt       <= 4'd0;
        r_frame_err <= 1'b1;
      end
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte       = r_byte;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 keyboard host receive controller. Merges E0/F0 prefix
// bytes into key events and buffers them in a fall-through FIFO.
// Optional macro PS2_TIMEOUT_EN enables the partial-frame watchdog.
// Ports:
//   i_clk, i_rst        system clock (>= 8x PS/2 clock), sync active-high reset
//   i_ps2_clk/data      asynchronous PS/2 lines
//   o_evt_valid         FIFO non-empty; head on o_evt_code/o_evt_ext/o_evt_brk
//   i_evt_pop           consume head event (ignored when empty)
//   o_frame_err         one-cycle pulse on a dropped frame
//   o_overflow          sticky, event dropped on full FIFO; i_ovf_clr clears
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_evt_valid,
  output logic [7:0] o_evt_code,
  output logic       o_evt_ext,
  output logic       o_evt_brk,
  input  logic       i_evt_pop,
  output logic       o_frame_err,
  output logic       o_overflow,
  input  logic       i_ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("ps2_kbd_ctrl: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic       w_byte_valid;
  logic [7:0] w_byte;

  ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ps2_clk    (i_ps2_clk),
    .i_ps2_data   (i_ps2_data),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_frame_err  (o_frame_err)
  );

  // Prefix assembler. Flags only change on accepted bytes, so they survive
  // dropped frames.
  logic     r_ext, r_brk;
  logic     w_is_ext, w_is_brk, w_push;
  ps2_evt_t w_evt;

  assign w_is_ext = w_byte_valid && (w_byte == PS2_EXT_PREFIX);
  assign w_is_brk = w_byte_valid && (w_byte == PS2_BRK_PREFIX);
  assign w_push   = w_byte_valid && !w_is_ext && !w_is_brk;

  always_comb begin
    w_evt      = '0;
    w_evt.ext  = r_ext;
    w_evt.brk  = r_brk;
    w_evt.code = w_byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_is_ext) begin
      r_ext <= 1'b1;
    end else if (w_is_brk) begin
      r_brk <= 1'b1;
    end else if (w_push) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end
  end

  // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
  ps2_evt_t      r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          r_overflow;
  logic          w_empty, w_full, w_pop, w_do_push;
  ps2_evt_t      w_head;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = i_evt_pop && !w_empty;
  // A pop on a full FIFO frees the slot the push needs in the same cycle.
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= w_evt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_do_push) r_overflow <= 1'b1;
      else if (i_ovf_clr)       r_overflow <= 1'b0;
    end
  end

  // Head fields are masked while empty so stale or unwritten entries never show.
  assign o_evt_valid = !w_empty;
  assign o_evt_code  = w_empty ? 8'h00 : w_head.code;
  assign o_evt_ext   = !w_empty && w_head.ext;
  assign o_evt_brk   = !w_empty && w_head.brk;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: drives PS/2 frames bit by bit and checks
// decoded events, frame errors, overflow and FIFO ordering.
module tb_ps2_kbd_ctrl;

  localparam int TB_TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_pop = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid, evt_ext, evt_brk, frame_err, overflow;
  logic [7:0] evt_code;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_evt_valid (evt_valid),
    .o_evt_code  (evt_code),
    .o_evt_ext   (evt_ext),
    .o_evt_brk   (evt_brk),
    .i_evt_pop   (evt_pop),
    .o_frame_err (frame_err),
    .o_overflow  (overflow),
    .i_ovf_clr   (ovf_clr)
  );

  always @(negedge clk) if (frame_err) err_cnt++;

  // Half-period of the PS/2 clock in system cycles.
  localparam int HALF = 10;

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  // Sends one frame. lat = cycles from the stop-bit fall until evt_valid is
  // seen (-1 if not within 8). pop_at_push asserts pop in the push cycle.
  task automatic send_frame(input logic [7:0] b, input bit flip_par,
                            input bit pop_at_push, output int lat);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    lat = -1;
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = f[10];
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (evt_valid && lat < 0) lat = k;
      if (pop_at_push && k == 3) evt_pop = 1'b1;
      if (k == 4) evt_pop = 1'b0;
    end
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string nm, input logic [7:0] code,
                           input logic ext, input logic brk);
    n_cmp++;
    if ({evt_valid, evt_ext, evt_brk, evt_code} !== {1'b1, ext, brk, code}) begin
      n_bad++;
      $display("FAIL %s: got v=%b e=%b b=%b c=%h, want v=1 e=%b b=%b c=%h",
               nm, evt_valid, evt_ext, evt_brk, evt_code, ext, brk, code);
    end
    evt_pop = 1'b1;
    @(posedge clk);
    #1 evt_pop = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if ({evt_valid, evt_code, evt_ext, evt_brk, frame_err, overflow} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b c=%h e=%b b=%b fe=%b ov=%b, want all 0",
               evt_valid, evt_code, evt_ext, evt_brk, frame_err, overflow);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_empty: got valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_basic;
    int lat, e0;
    e0 = err_cnt;
    send_frame(8'h1C, 0, 0, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL latency: got %0d want 4", lat);
    end
    pop_check("basic_1C", 8'h1C, 1'b0, 1'b0);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_single_event: got valid=%b want 0", evt_valid);
    end
    n_cmp++;
    if (err_cnt - e0 !== 0) begin
      n_bad++;
      $display("FAIL basic_no_err: got %0d errs want 0", err_cnt - e0);
    end
  endtask

  task automatic test_break;
    int lat;
    send_frame(8'hF0, 0, 0, lat);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL brk_prefix_no_event: got valid=%b want 0", evt_valid);
    end
    send_frame(8'h1C, 0, 0, lat);
    pop_check("brk_1C", 8'h1C, 1'b0, 1'b1);
  endtask

  task automatic test_ext_brk;
    int lat;
    send_frame(8'hE0, 0, 0, lat);
    send_frame(8'hF0, 0, 0, lat);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ext_prefix_no_event: got valid=%b want 0", evt_valid);
    end
    send_frame(8'h75, 0, 0, lat);
    pop_check("ext_brk_75", 8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 0, 0, lat);
    pop_check("flags_cleared_75", 8'h75, 1'b0, 1'b0);
  endtask

  task automatic test_parity_err;
    int lat, e0;
    e0 = err_cnt;
    send_frame(8'h1C, 1, 0, lat);
    n_cmp++;
    if (evt_valid !== 1'b0 || err_cnt - e0 !== 1) begin
      n_bad++;
      $display("FAIL parity_err: got valid=%b errs=%0d want valid=0 errs=1",
               evt_valid, err_cnt - e0);
    end
    send_frame(8'hF0, 0, 0, lat);
    send_frame(8'h1C, 0, 0, lat);
    pop_check("after_err_F0_1C", 8'h1C, 1'b0, 1'b1);
  endtask

  task automatic test_overflow;
    int lat;
    for (int c = 1; c <= 9; c++) send_frame(8'(c), 0, 0, lat);
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set: got %b want 1", overflow);
    end
    for (int c = 1; c <= 8; c++) pop_check("ovf_order", 8'(c), 1'b0, 1'b0);
    n_cmp++;
    if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_drained: got valid=%b ovf=%b want valid=0 ovf=1",
               evt_valid, overflow);
    end
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clr: got %b want 0", overflow);
    end
    for (int c = 8'h11; c <= 8'h18; c++) send_frame(8'(c), 0, 0, lat);
    send_frame(8'h19, 0, 1, lat);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL pop_push_full_ovf: got %b want 0", overflow);
    end
    for (int c = 8'h12; c <= 8'h19; c++) pop_check("pop_push_full", 8'(c), 1'b0, 1'b0);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL pop_push_full_count: got valid=%b want 0 after 8 pops", evt_valid);
    end
  endtask

`ifdef PS2_TIMEOUT_EN
  task automatic test_timeout;
    int lat, e0;
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    repeat (TB_TIMEOUT + 10) @(posedge clk);
    #1;
    n_cmp++;
    if (err_cnt - e0 !== 1) begin
      n_bad++;
      $display("FAIL timeout_err: got %0d errs want 1", err_cnt - e0);
    end
    send_frame(8'h1C, 0, 0, lat);
    pop_check("after_timeout_1C", 8'h1C, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_ext_brk();
    test_parity_err();
    test_overflow();
`ifdef PS2_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
